// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Reports framing errors as a one-cycle pulse and FIFO overflow as a sticky flag.
module uart_rx_monitor #(
    parameter int unsigned CLKS_PER_BIT = 4167,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ser_rx,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        empty,
    output logic        full,
    output logic        overflow,
    output logic        frame_error,
    output logic        busy,
    output logic [15:0] rx_count
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    localparam logic [CntW-1:0] HalfCnt  = CntW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CntW-1:0] LastCnt  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [OccW-1:0] DepthOcc = OccW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_meta_q, rx_s_q;
    logic            push;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0] occ_q, occ_d;
    logic            overflow_q;
    logic [15:0]     rx_count_q;
    logic            do_push, do_pop, drop;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= ser_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d     = StStart;
                    cycle_cnt_d = '0;
                end
            end
            StStart: begin
                if (cycle_cnt_q == HalfCnt) begin
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d     = StData;
                        cycle_cnt_d = '0;
                        bit_cnt_d   = '0;
                    end
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cycle_cnt_q == LastCnt) begin
                    cycle_cnt_d = '0;
                    shift_d     = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cycle_cnt_q == LastCnt) begin
                    cycle_cnt_d = '0;
                    state_d     = rx_s_q ? StIdle : StWaitIdle;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            StWaitIdle: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        push        = 1'b0;
        frame_error = 1'b0;
        busy        = (state_q != StIdle);
        if (state_q == StStop && cycle_cnt_q == LastCnt) begin
            push        = rx_s_q;
            frame_error = !rx_s_q;
        end
    end

    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            rx_count_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (do_push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                rx_count_q <= rx_count_q + 16'd1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign empty    = (occ_q == '0);
    assign full     = (occ_q == DepthOcc);
    assign rd_data  = empty ? 8'h00 : mem[rd_ptr_q];
    assign overflow = overflow_q;
    assign rx_count = rx_count_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: table of frames plus hand-written corner sequences,
// with a byte scoreboard checked as the FIFO is drained.
module tb_uart_rx_monitor;

    localparam int unsigned CPB   = 8;
    localparam int unsigned DEPTH = 16;
    // Negedges from driving the start bit to the negedge just before the push edge.
    localparam int unsigned PushOfs = 78;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ser_rx = 1'b1;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        frame_error;
    logic        busy;
    logic [15:0] rx_count;

    always #5 clock = ~clock;

    uart_rx_monitor #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ser_rx     (ser_rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .frame_error(frame_error),
        .busy       (busy),
        .rx_count   (rx_count)
    );

    typedef struct {
        logic [7:0]  data;
        logic        stop_bit;
        logic [15:0] exp_count;
        int          exp_fe;
    } vec_t;

    vec_t       vecs [14];
    logic [7:0] msg  [12];
    logic [7:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         fe_count = 0;
    int         fe_base;

    always @(negedge clock) begin
        if (frame_error) fe_count <= fe_count + 1;
    end

    initial begin
        repeat (200000) @(posedge clock);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        ser_rx = v;
        repeat (n * CPB) @(negedge clock);
    endtask

    // Called at a negedge; returns at the negedge that ends the stop period.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
        drive_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
        drive_bit(stop, stop_bits);
    endtask

    task automatic pop_check(input string name);
        int t;
        logic [7:0] exp;
        t = 0;
        while (empty && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (empty) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: FIFO stayed empty, expected a byte", name);
        end else if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got byte %0h, expected none", name, rd_data);
        end else begin
            exp = exp_q.pop_front();
            check(name, 32'(rd_data), 32'(exp));
            rd_en = 1'b1;
            @(negedge clock);
            rd_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ser_rx = 1'b1;
        rd_en  = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check({tag, "_empty"}, 32'(empty), 32'h1);
        check({tag, "_full"}, 32'(full), 32'h0);
        check({tag, "_overflow"}, 32'(overflow), 32'h0);
        check({tag, "_frame_error"}, 32'(frame_error), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_rx_count"}, 32'(rx_count), 32'h0);
    endtask

    initial begin
        msg = '{8'h4C, 8'h41, 8'h20, 8'h42, 8'h45, 8'h43,
                8'h20, 8'h64, 8'h6F, 8'h6E, 8'h65, 8'h0A};
        for (int i = 0; i < 12; i++) begin
            vecs[i] = '{data: msg[i], stop_bit: 1'b1, exp_count: 16'(i + 1), exp_fe: 0};
        end
        vecs[12] = '{data: 8'h55, stop_bit: 1'b0, exp_count: 16'd12, exp_fe: 1};
        vecs[13] = '{data: 8'h33, stop_bit: 1'b1, exp_count: 16'd13, exp_fe: 1};

        // Reset state
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Single frame 'A'
        fe_base = fe_count;
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 1);
        check("single_empty", 32'(empty), 32'h0);
        check("single_count", 32'(rx_count), 32'd1);
        pop_check("single_data");
        check("single_empty_after_pop", 32'(empty), 32'h1);
        check("single_no_fe", 32'(fe_count - fe_base), 32'd0);

        // Table: back-to-back string, then a bad-stop frame and a recovery frame
        do_reset();
        fe_base = fe_count;
        for (int i = 0; i < 14; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_bit, 1);
            if (vecs[i].stop_bit) exp_q.push_back(vecs[i].data);
            else drive_bit(1'b1, 1);
            check($sformatf("vec%0d_count", i), 32'(rx_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_fe", i), 32'(fe_count - fe_base), 32'(vecs[i].exp_fe));
        end
        for (int k = 0; k < 13; k++) pop_check($sformatf("vec_pop%0d", k));
        check("vec_empty_end", 32'(empty), 32'h1);
        check("vec_no_overflow", 32'(overflow), 32'h0);

        // Start-bit glitch
        do_reset();
        ser_rx = 1'b0;
        repeat (2) @(negedge clock);
        ser_rx = 1'b1;
        repeat (2) @(negedge clock);
        check("glitch_busy", 32'(busy), 32'h1);
        repeat (20) @(negedge clock);
        check("glitch_idle", 32'(busy), 32'h0);
        check("glitch_empty", 32'(empty), 32'h1);
        check("glitch_count", 32'(rx_count), 32'd0);

        // Stop bit held low for 20 bit times (break)
        do_reset();
        fe_base = fe_count;
        send_frame(8'h55, 1'b0, 20);
        check("break_fe_once", 32'(fe_count - fe_base), 32'd1);
        check("break_busy", 32'(busy), 32'h1);
        check("break_empty", 32'(empty), 32'h1);
        drive_bit(1'b1, 2);
        check("break_released", 32'(busy), 32'h0);
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, 1);
        check("break_next_count", 32'(rx_count), 32'd1);
        pop_check("break_next_data");
        check("break_fe_total", 32'(fe_count - fe_base), 32'd1);

        // Overflow: 17 frames, no reads
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1);
            if (i == 15) begin
                check("ovf_full16", 32'(full), 32'h1);
                check("ovf_not_yet", 32'(overflow), 32'h0);
            end
        end
        check("ovf_full", 32'(full), 32'h1);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_count", 32'(rx_count), 32'd16);
        for (int k = 0; k < 16; k++) pop_check($sformatf("ovf_pop%0d", k));
        check("ovf_empty", 32'(empty), 32'h1);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Push and pop on the same edge while full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h80 + i));
            send_frame(8'(8'h80 + i), 1'b1, 1);
        end
        exp_q.push_back(8'h90);
        fork
            send_frame(8'h90, 1'b1, 1);
            begin
                logic [7:0] e;
                repeat (PushOfs) @(negedge clock);
                check("simul_full_before", 32'(full), 32'h1);
                e = exp_q.pop_front();
                check("simul_head", 32'(rd_data), 32'(e));
                rd_en = 1'b1;
                @(negedge clock);
                rd_en = 1'b0;
            end
        join
        check("simul_full_after", 32'(full), 32'h1);
        check("simul_no_overflow", 32'(overflow), 32'h0);
        check("simul_count", 32'(rx_count), 32'd17);
        send_frame(8'h91, 1'b1, 1);
        check("simul_drop_overflow", 32'(overflow), 32'h1);
        check("simul_drop_count", 32'(rx_count), 32'd17);
        for (int k = 0; k < 16; k++) pop_check($sformatf("simul_pop%0d", k));
        check("simul_empty", 32'(empty), 32'h1);

        // Reset during DATA of 0x7E
        do_reset();
        fe_base = fe_count;
        drive_bit(1'b0, 1);
        drive_bit(1'b0, 1);
        drive_bit(1'b1, 2);
        reset  = 1'b1;
        ser_rx = 1'b1;
        @(negedge clock);
        check_reset_values("midreset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        drive_bit(1'b1, 2);
        check_reset_values("midreset_rel");
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1);
        check("midreset_count", 32'(rx_count), 32'd1);
        pop_check("midreset_data");
        check("midreset_no_fe", 32'(fe_count - fe_base), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
